jk_bank_sched: RTL and testbench

- Round-robin command scheduler that shares one external bank of WIDTH JK flip-flops between NREQ requesters.
- Each requester submits an op (hold/clear/set/toggle) plus a bit mask.
- The scheduler drives the bank's J/K lines for exactly one cycle, samples the bank's Q, checks it against the expected result, and returns a tagged response.
- Sits between software-visible command ports and the jk_ff bank.

---
 rtl/jk_pkg.sv | 43 ++++
 rtl/jk_rr_arb.sv | 44 ++++
 rtl/jk_bank_sched.sv | 161 ++++++++++++++++
 tb/tb_jk_bank_sched.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// ---------------------------------------------------------------------------
// jk_pkg
// Shared definitions for the JK bank scheduler:
//   - 2-bit op encodings driven by requesters (hold / clear / set / toggle)
//   - scheduler state enumeration
//   - exp_q(): the value a correctly working bank must show after an op
// exp_q works on a fixed-width word (JK_MAX_W bits) so it can live in the
// package independent of the instantiating module's WIDTH; callers zero-extend
// their operands and truncate the result back to WIDTH. WIDTH must therefore
// not exceed JK_MAX_W.
// ---------------------------------------------------------------------------
package jk_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int JK_MAX_W = 64;
    typedef logic [JK_MAX_W-1:0] jk_word_t;

    // Expected bank contents after applying op to the cells selected by mask,
    // starting from the pre-op snapshot q0.
    function automatic jk_word_t exp_q(input logic [1:0] op,
                                       input jk_word_t   q0,
                                       input jk_word_t   mask);
        case (op)
            OP_HOLD: exp_q = q0;
            OP_CLR:  exp_q = q0 & ~mask;
            OP_SET:  exp_q = q0 | mask;
            OP_TGL:  exp_q = q0 ^ mask;
            default: exp_q = q0;
        endcase
    endfunction

endpackage

// File: rtl/jk_rr_arb.sv
// ---------------------------------------------------------------------------
// jk_rr_arb
// Combinational round-robin arbiter. Searches the valid vector starting one
// position after the last-served requester (wrapping modulo NREQ) and
// returns a one-hot grant plus the binary id of the winner.
// The last-served pointer is owned by the caller.
// Ports:
//   valid_i   [NREQ-1:0]  requester valid vector
//   last_i    [IDW-1:0]   id of the requester served most recently
//   grant_o   [NREQ-1:0]  one-hot grant, all zero when nothing is valid
//   gnt_id_o  [IDW-1:0]   binary id of the granted requester (0 if none)
//   found_o               at least one requester is valid
// ---------------------------------------------------------------------------
module jk_rr_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IDW-1:0]  last_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  gnt_id_o,
    output logic            found_o
);

    int idx;

    // Offsets 1..NREQ visit every requester once, the last-served one last,
    // which gives each continuously valid requester a turn within NREQ grants.
    always_comb begin
        grant_o  = '0;
        gnt_id_o = '0;
        found_o  = 1'b0;
        idx      = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_i) + i) % NREQ;
            if (!found_o && valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                gnt_id_o     = IDW'(idx);
                found_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jk_bank_sched.sv
// ---------------------------------------------------------------------------
// jk_bank_sched
// Round-robin command scheduler sharing one external bank of WIDTH JK
// flip-flops between NREQ requesters. Each accepted command drives J/K for
// exactly one cycle, then the bank's Q is sampled, compared with the value
// the op should have produced, and returned as a tagged response.
//
// Sequence per command: IDLE (accept) -> APPLY -> SAMPLE -> RESP -> IDLE.
// rsp_valid rises three cycles after the accept cycle; at most one command
// is in flight, so the minimum issue interval is four cycles.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req_valid [NREQ]    per-requester command valid
//   req_op    [2*NREQ]  per-requester op (00 hold, 01 clear, 10 set, 11 toggle)
//   req_mask  [W*NREQ]  per-requester cell-select mask
//   req_ready [NREQ]    one-hot grant, only ever nonzero in IDLE
//   jk_j, jk_k [W]      J/K lines to the bank, nonzero only in APPLY
//   jk_q       [W]      bank Q outputs (bank updates on clk rising edge)
//   rsp_valid / rsp_ready  response handshake, held until accepted
//   rsp_id    [IDW]     id of the served requester
//   rsp_q     [W]       Q sampled after the op
//   rsp_err             sampled Q differs from the expected value
// ---------------------------------------------------------------------------
module jk_bank_sched
    import jk_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int IDW   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_mask,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      jk_j,
    output logic [WIDTH-1:0]      jk_k,
    input  logic [WIDTH-1:0]      jk_q,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_q,
    output logic                  rsp_err
);

    // Control state
    state_e         state_q;
    logic [IDW-1:0] last_q;

    // Latched command
    logic [1:0]       op_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] q0_q;
    logic [IDW-1:0]   id_q;

    // Registered outputs
    logic [WIDTH-1:0] jk_j_q;
    logic [WIDTH-1:0] jk_k_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_q_q;
    logic             rsp_err_q;

    // Arbitration
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_found;
    logic            accept;

    // Next-state values for the J/K lines and the expected result
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_mask;
    logic [WIDTH-1:0] jk_j_d;
    logic [WIDTH-1:0] jk_k_d;
    logic [WIDTH-1:0] exp_d;

    jk_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .valid_i  (req_valid),
        .last_i   (last_q),
        .grant_o  (grant),
        .gnt_id_o (gnt_id),
        .found_o  (gnt_found)
    );

    // Grants are only offered while idle, so a grant can never overlap an
    // op that is still in flight.
    assign req_ready = (state_q == IDLE) ? grant : '0;
    assign accept    = (state_q == IDLE) && gnt_found;

    assign sel_op   = req_op[int'(gnt_id)*2 +: 2];
    assign sel_mask = req_mask[int'(gnt_id)*WIDTH +: WIDTH];

    // op[1] selects J, op[0] selects K: hold 00, clear 0/K, set J/0, toggle J/K.
    // Unmasked cells always see J=K=0.
    assign jk_j_d = sel_op[1] ? sel_mask : '0;
    assign jk_k_d = sel_op[0] ? sel_mask : '0;

    assign exp_d = WIDTH'(exp_q(op_q, jk_word_t'(q0_q), jk_word_t'(mask_q)));

    always_ff @(posedge clk) begin
        if (rst) begin
            // Aborts any op in flight: no response, J/K released next cycle.
            state_q     <= IDLE;
            last_q      <= IDW'(NREQ - 1);
            jk_j_q      <= '0;
            jk_k_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q_q     <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= sel_op;
                        mask_q  <= sel_mask;
                        q0_q    <= jk_q;
                        id_q    <= gnt_id;
                        last_q  <= gnt_id;
                        jk_j_q  <= jk_j_d;
                        jk_k_q  <= jk_k_d;
                        state_q <= APPLY;
                    end
                end
                APPLY: begin
                    // Bank captures J/K on this edge; release the lines.
                    jk_j_q  <= '0;
                    jk_k_q  <= '0;
                    state_q <= SAMPLE;
                end
                SAMPLE: begin
                    rsp_q_q     <= jk_q;
                    rsp_err_q   <= (jk_q != exp_d);
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign jk_j      = jk_j_q;
    assign jk_k      = jk_k_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_q     = rsp_q_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_jk_bank_sched.sv
// ---------------------------------------------------------------------------
// tb_jk_bank_sched
// Self-checking bench for jk_bank_sched with WIDTH=8, NREQ=2. Contains a JK
// bank model (optionally forced stuck at a value) and a reference for the
// expected J/K drive, round-robin order and response contents.
// ---------------------------------------------------------------------------
module tb_jk_bank_sched;

    localparam int WIDTH = 8;
    localparam int NREQ  = 2;
    localparam int IDW   = 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_mask;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      jk_j;
    logic [WIDTH-1:0]      jk_k;
    logic [WIDTH-1:0]      jk_q;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_q;
    logic                  rsp_err;

    // Bank model
    logic [WIDTH-1:0] bank;
    logic             load_en;
    logic [WIDTH-1:0] load_val;
    logic             stuck_en;
    logic [WIDTH-1:0] stuck_val;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int         id;
        logic [7:0] q;
    } exp_t;
    exp_t sb[$];

    jk_bank_sched #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_mask  (req_mask),
        .req_ready (req_ready),
        .jk_j      (jk_j),
        .jk_k      (jk_k),
        .jk_q      (jk_q),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // JK characteristic equation: Q+ = J&~Q | ~K&Q
    always @(posedge clk) begin
        if (load_en) bank <= load_val;
        else         bank <= (jk_j & ~bank) | (~jk_k & bank);
    end

    assign jk_q = stuck_en ? stuck_val : bank;

    function automatic logic [7:0] model_apply(input logic [1:0] op, input logic [7:0] q0,
                                               input logic [7:0] m);
        case (op)
            2'b00:   return q0;
            2'b01:   return q0 & ~m;
            2'b10:   return q0 | m;
            default: return q0 ^ m;
        endcase
    endfunction

    function automatic logic [7:0] model_j(input logic [1:0] op, input logic [7:0] m);
        return (op == 2'b10 || op == 2'b11) ? m : 8'h00;
    endfunction

    function automatic logic [7:0] model_k(input logic [1:0] op, input logic [7:0] m);
        return (op == 2'b01 || op == 2'b11) ? m : 8'h00;
    endfunction

    task automatic load_bank(input logic [7:0] v);
        @(negedge clk);
        load_en  = 1'b1;
        load_val = v;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete command from a single valid requester, checked at every
    // stage. hold = cycles rsp_ready stays low in RESP. keep_other raises the
    // other requester's valid once the command is in flight.
    task automatic do_cmd(input int id, input logic [1:0] op, input logic [7:0] m,
                          input int hold, input bit keep_other);
        logic [7:0] q0, expq, exp_rsp;
        logic       exp_err;
        logic [1:0] onehot;
        logic [0:0] eid;
        eid    = 1'(id);
        onehot = 2'b01 << id;

        @(negedge clk);
        req_valid         = '0;
        req_valid[id]     = 1'b1;
        req_op[id*2 +: 2] = op;
        req_mask[id*8 +: 8] = m;
        rsp_ready         = 1'b0;
        #1;
        n_total++;
        if (req_ready !== onehot) $display("FAIL grant: req_ready=%b expected %b", req_ready, onehot);
        else n_pass++;
        q0 = jk_q;

        // APPLY
        @(negedge clk);
        req_valid[id] = 1'b0;
        if (keep_other) req_valid[1-id] = 1'b1;
        #1;
        n_total++;
        if (jk_j !== model_j(op, m) || jk_k !== model_k(op, m))
            $display("FAIL apply_jk: j=%h k=%h expected j=%h k=%h", jk_j, jk_k, model_j(op, m), model_k(op, m));
        else n_pass++;
        n_total++;
        if (req_ready !== 2'b00) $display("FAIL apply_ready: req_ready=%b expected 00", req_ready);
        else n_pass++;

        // SAMPLE
        @(negedge clk);
        #1;
        n_total++;
        if (jk_j !== 8'h00 || jk_k !== 8'h00 || rsp_valid !== 1'b0)
            $display("FAIL sample: j=%h k=%h rsp_valid=%b expected 00 00 0", jk_j, jk_k, rsp_valid);
        else n_pass++;

        expq    = model_apply(op, q0, m);
        exp_rsp = stuck_en ? stuck_val : expq;
        exp_err = (exp_rsp != expq);

        // RESP
        @(negedge clk);
        #1;
        n_total++;
        if (rsp_valid !== 1'b1 || rsp_id !== eid || rsp_q !== exp_rsp || rsp_err !== exp_err)
            $display("FAIL resp: valid=%b id=%0d q=%h err=%b expected 1 %0d %h %b",
                     rsp_valid, rsp_id, rsp_q, rsp_err, eid, exp_rsp, exp_err);
        else n_pass++;
        n_total++;
        if (jk_j !== 8'h00 || jk_k !== 8'h00 || req_ready !== 2'b00)
            $display("FAIL resp_idle_lines: j=%h k=%h ready=%b expected 00 00 00", jk_j, jk_k, req_ready);
        else n_pass++;

        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            #1;
            n_total++;
            if ({rsp_valid, rsp_id, rsp_q, rsp_err, req_ready} !== {1'b1, eid, exp_rsp, exp_err, 2'b00})
                $display("FAIL backpressure_hold: valid=%b id=%0d q=%h err=%b ready=%b expected 1 %0d %h %b 00",
                         rsp_valid, rsp_id, rsp_q, rsp_err, req_ready, eid, exp_rsp, exp_err);
            else n_pass++;
        end
        rsp_ready = 1'b1;

        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        n_total++;
        if (rsp_valid !== 1'b0) $display("FAIL rsp_drop: rsp_valid=%b expected 0", rsp_valid);
        else n_pass++;
        if (keep_other) begin
            n_total++;
            if (req_ready !== (2'b01 << (1 - id)))
                $display("FAIL next_grant: req_ready=%b expected %b", req_ready, 2'b01 << (1 - id));
            else n_pass++;
            req_valid = '0;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_mask  = '0;
        rsp_ready = 1'b0;
        load_en   = 1'b0;
        load_val  = '0;
        stuck_en  = 1'b0;
        stuck_val = '0;
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if ({jk_j, jk_k, req_ready, rsp_valid, rsp_id, rsp_q, rsp_err} !== '0)
            $display("FAIL reset_state: j=%h k=%h ready=%b valid=%b id=%0d q=%h err=%b expected all 0",
                     jk_j, jk_k, req_ready, rsp_valid, rsp_id, rsp_q, rsp_err);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        load_bank(8'h00);
        do_cmd(0, 2'b10, 8'h0F, 0, 1'b0);
        n_total++;
        if (rsp_q !== 8'h0F) $display("FAIL basic_set_q: rsp_q=%h expected 0f", rsp_q);
        else n_pass++;
        do_cmd(1, 2'b11, 8'hFF, 0, 1'b0);
        n_total++;
        if (rsp_q !== 8'hF0) $display("FAIL basic_toggle_q: rsp_q=%h expected f0", rsp_q);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int grants, resps, last_c, expid, refresh;
        logic [1:0] op;
        logic [7:0] m;
        exp_t e;
        apply_reset();
        load_bank(8'($urandom));
        @(negedge clk);
        req_op    = 4'($urandom);
        req_mask  = 16'($urandom);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        grants = 0; resps = 0; last_c = 0; expid = 0; refresh = -1;
        sb.delete();
        for (int c = 0; c < 60 && (grants < 4 || resps < 4); c++) begin
            if (c > 0) @(negedge clk);
            if (refresh >= 0) begin
                req_op[refresh*2 +: 2]   = 2'($urandom);
                req_mask[refresh*8 +: 8] = 8'($urandom);
                refresh = -1;
            end
            #1;
            if (req_ready !== 2'b00) begin
                n_total++;
                if (req_ready !== (2'b01 << expid))
                    $display("FAIL rr_order: grant %0d req_ready=%b expected %b", grants, req_ready, 2'b01 << expid);
                else n_pass++;
                if (grants > 0) begin
                    n_total++;
                    if (c - last_c != 4) $display("FAIL rr_interval: interval=%0d expected 4", c - last_c);
                    else n_pass++;
                end
                op   = req_op[expid*2 +: 2];
                m    = req_mask[expid*8 +: 8];
                e.id = expid;
                e.q  = model_apply(op, jk_q, m);
                sb.push_back(e);
                refresh = expid;
                expid   = 1 - expid;
                last_c  = c;
                grants++;
            end
            if (rsp_valid === 1'b1) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL rr_resp: unexpected response id=%0d q=%h", rsp_id, rsp_q);
                end else begin
                    e = sb.pop_front();
                    if (rsp_id !== 1'(e.id) || rsp_q !== e.q || rsp_err !== 1'b0)
                        $display("FAIL rr_resp: id=%0d q=%h err=%b expected %0d %h 0", rsp_id, rsp_q, rsp_err, e.id, e.q);
                    else n_pass++;
                end
                resps++;
            end
        end
        n_total++;
        if (grants < 4 || resps < 4) $display("FAIL rr_timeout: grants=%0d resps=%0d expected 4 4", grants, resps);
        else n_pass++;
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_stuck_err();
        @(negedge clk);
        stuck_val = 8'hAA;
        stuck_en  = 1'b1;
        do_cmd(0, 2'b01, 8'h02, 0, 1'b0);
        n_total++;
        if (rsp_q !== 8'hAA || rsp_err !== 1'b1)
            $display("FAIL stuck_err: rsp_q=%h err=%b expected aa 1", rsp_q, rsp_err);
        else n_pass++;
        stuck_en = 1'b0;
    endtask

    task automatic test_backpressure();
        load_bank(8'($urandom));
        do_cmd(0, 2'($urandom), 8'($urandom), 10, 1'b1);
    endtask

    task automatic test_random();
        load_bank(8'($urandom));
        for (int i = 0; i < 8; i++)
            do_cmd(int'($urandom_range(0, 1)), 2'($urandom), (i == 0) ? 8'h00 : 8'($urandom),
                   int'($urandom_range(0, 2)), 1'b0);
    endtask

    task automatic test_reset_apply();
        load_bank(8'h00);
        @(negedge clk);
        req_valid     = 2'b01;
        req_op[1:0]   = 2'b10;
        req_mask[7:0] = 8'hFF;
        rsp_ready     = 1'b0;
        @(negedge clk);
        req_valid = '0;
        #1;
        n_total++;
        if (jk_j !== 8'hFF) $display("FAIL rst_apply_active: jk_j=%h expected ff", jk_j);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if (jk_j !== 8'h00 || jk_k !== 8'h00 || rsp_valid !== 1'b0)
            $display("FAIL rst_apply_abort: j=%h k=%h rsp_valid=%b expected 00 00 0", jk_j, jk_k, rsp_valid);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            n_total++;
            if (rsp_valid !== 1'b0 || jk_j !== 8'h00) $display("FAIL rst_apply_no_rsp: rsp_valid=%b jk_j=%h expected 0 00", rsp_valid, jk_j);
            else n_pass++;
        end
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        n_total++;
        if (req_ready !== 2'b01) $display("FAIL rst_apply_first_grant: req_ready=%b expected 01", req_ready);
        else n_pass++;
        req_valid = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_stuck_err();
        test_backpressure();
        test_random();
        test_reset_apply();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
